// File: rtl/mips_cache_pkg.sv
// mips_cache_pkg: shared cache line geometry, read-fill state encoding and line-base helper.
package mips_cache_pkg;

    localparam int LINE_BITS  = 2;
    localparam int LINE_WORDS = 2 ** LINE_BITS;

    typedef enum logic [1:0] {
        FILL_IDLE  = 2'd0,
        FILL_DRAIN = 2'd1,
        FILL_READ  = 2'd2,
        FILL_DONE  = 2'd3
    } fill_state_e;

    function automatic logic [31:0] line_base(input logic [31:0] addr, input int bits);
        return addr & ~((32'd1 << (bits + 2)) - 32'd1);
    endfunction

endpackage

// File: rtl/mips_cache_readfill.sv
// mips_cache_readfill: fetches a missed cache line word-by-word over Avalon-MM after draining the write buffer.
// Define MIPS_CACHE_CRITICAL_WORD_FIRST_EN to start the fill at the missed word and wrap around the line.
module mips_cache_readfill
    import mips_cache_pkg::*;
#(
    parameter int LINE_BITS = mips_cache_pkg::LINE_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 miss,
    input  logic [31:0]          miss_addr,
    output logic                 busy,
    input  logic                 wb_empty,
    output logic                 wb_active,
    output logic [31:0]          mem_address,
    output logic                 mem_read,
    output logic [3:0]           mem_byteenable,
    input  logic                 mem_waitrequest,
    input  logic [31:0]          mem_readdata,
    output logic                 fill_valid,
    output logic [LINE_BITS-1:0] fill_word,
    output logic [31:0]          fill_data,
    output logic [31:0]          fill_tag_addr,
    output logic                 fill_done,
    output logic [1:0]           state_out
);

    localparam int LINE_WORDS = 2 ** LINE_BITS;
    localparam logic [1:0] S_IDLE  = FILL_IDLE;
    localparam logic [1:0] S_DRAIN = FILL_DRAIN;
    localparam logic [1:0] S_READ  = FILL_READ;
    localparam logic [1:0] S_DONE  = FILL_DONE;

    logic [1:0]           state;
    logic [LINE_BITS-1:0] idx;
    logic [LINE_BITS:0]   cnt;
    logic [31:0]          base;
    logic [LINE_BITS-1:0] start_idx;
    logic                 last;

`ifdef MIPS_CACHE_CRITICAL_WORD_FIRST_EN
    assign start_idx = miss_addr[LINE_BITS+1:2];
`else
    assign start_idx = '0;
`endif

    // Termination uses the accepted-word count, so a wrapped index cannot end the fill early
    assign last = cnt == (LINE_BITS + 1)'(LINE_WORDS - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            idx   <= '0;
            cnt   <= '0;
            base  <= '0;
        end else if (state == S_IDLE) begin
            if (miss) begin
                state <= S_DRAIN;
                idx   <= start_idx;
                cnt   <= '0;
                base  <= line_base(miss_addr, LINE_BITS);
            end
        end else if (state == S_DRAIN) begin
            if (wb_empty) state <= S_READ;
        end else if (state == S_READ) begin
            if (!mem_waitrequest) begin
                idx <= idx + 1'b1;
                cnt <= cnt + 1'b1;
                if (last) state <= S_DONE;
            end
        end else begin
            state <= S_IDLE;
        end
    end

    always_comb begin
        busy           = state != S_IDLE;
        wb_active      = state != S_READ;
        mem_read       = state == S_READ;
        mem_address    = base | {{(30 - LINE_BITS){1'b0}}, idx, 2'b00};
        mem_byteenable = 4'hF;
        fill_valid     = mem_read && !mem_waitrequest;
        fill_word      = idx;
        fill_data      = mem_readdata;
        fill_tag_addr  = base;
        fill_done      = state == S_DONE;
        state_out      = state;
    end

endmodule

// File: doc/mips_cache_readfill.md
Name: mips_cache_readfill

Overview:
- Read-side companion to the cache write buffer: on a data/instruction cache read miss, fetches the whole cache line from memory over the Avalon-MM master port, one word per read transaction.
- Streams each returned word into the cache data array.
- Preserves read-after-write ordering: waits for the write buffer to drain before reading, and holds the write buffer inactive while it owns the bus.

Parameters:
- LINE_BITS, 2, log2 of words per cache line (4 words default).
- LINE_WORDS, 2**LINE_BITS, words per line (derived; do not override).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- miss  input  1  read-miss request, sampled only in IDLE
- miss_addr  input  32  byte address of missed access
- busy  output  1  high in any state other than IDLE; CPU stalls on it
- wb_empty  input  1  write buffer empty flag
- wb_active  output  1  write buffer enable; low only in READ
- mem_address  output  32  Avalon word-aligned read address
- mem_read  output  1  Avalon read strobe
- mem_byteenable  output  4  always 4'hF
- mem_waitrequest  input  1  Avalon stall
- mem_readdata  input  32  Avalon read data, valid when mem_read && !mem_waitrequest
- fill_valid  output  1  per-word write strobe to cache data array
- fill_word  output  LINE_BITS  word index within line for fill_valid
- fill_data  output  32  word to write (combinationally mem_readdata)
- fill_tag_addr  output  32  latched line base address (miss_addr with low LINE_BITS+2 bits zeroed)
- fill_done  output  1  one-cycle pulse when whole line is written
- state_out  output  2  debug state

Behaviour:
- States: IDLE=0, DRAIN=1, READ=2, DONE=3.
- Reset: state IDLE; counter 0; latched address 0; busy=0, mem_read=0, fill_valid=0, fill_done=0, wb_active=1.
- Reset mid-operation returns to IDLE next edge with mem_read low. Partial line is discarded; the cache must not validate the line without fill_done.
- IDLE: on miss=1, latch the line base, set the word counter to the start index, go to DRAIN. miss in any other state is ignored.
- DRAIN: wb_active=1, mem_read=0. If wb_empty=1, go to READ next cycle. A single DRAIN cycle is spent even if the buffer is already empty.
- READ: wb_active=0; mem_read=1; mem_address = base | (counter<<2).
  - When mem_waitrequest=0: fill_valid=1, fill_word=counter, fill_data=mem_readdata (same cycle); counter increments mod LINE_WORDS.
  - After the LINE_WORDS-th accepted word, go to DONE. Address, counter and mem_read stay stable while mem_waitrequest=1.
- DONE: fill_done=1 for exactly one cycle, busy still 1, wb_active=1, then IDLE.
- Zero-wait latency: miss at cycle 0 → DRAIN cycle 1 → READ cycles 2..5 → DONE cycle 6 → IDLE cycle 7.
- Counter counts accepted words separately from the address index; a wrapped index never terminates early.
- The CPU issues no new writes while busy; the write buffer therefore stays empty throughout READ.

Optional Feature:
- Macro: MIPS_CACHE_CRITICAL_WORD_FIRST_EN.
- Defined: start index = miss_addr[LINE_BITS+1:2]; the index wraps mod LINE_WORDS. Example: miss word 2 gives order 2,3,0,1.
- Undefined: start index always 0; order 0,1,2,3.
- Word count, termination and latency are identical either way.

Decomposition:
- Shared package mips_cache_pkg: fill state enum typedef, LINE_BITS/LINE_WORDS constants, and the line-base mask function, reused by the cache controller and the write buffer bench.
- No sub-module: the block is a single FSM plus counter.

Test Plan:
- Reset, then idle with no stimulus → busy=0, mem_read=0, wb_active=1, state_out=0 for 10 cycles.
- miss=1, miss_addr=0x0000_1008, wb_empty=1, no waitrequest → reads at 0x1000, 0x1004, 0x1008, 0x100C on cycles 2-5, each with fill_valid. fill_done on cycle 6. With the macro defined, the order is 0x1008, 0x100C, 0x1000, 0x1004.
- wb_empty held 0 for 5 cycles after miss → mem_read stays 0 and wb_active stays 1 until wb_empty rises; READ begins the cycle after.
- mem_waitrequest=1 for 3 cycles on word 1 → mem_address constant, fill_valid=0 during the stall, no word skipped or duplicated, exactly 4 fill_valid pulses.
- rst asserted during READ after 2 words → IDLE next cycle, mem_read=0, no fill_done. A new miss afterwards completes a full 4-word fill.
- Second miss pulse while busy, plus miss held high through DONE → the held miss starts a new fill only after returning to IDLE; the pulse during busy is ignored.
